// File: rtl/mul_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_product_accumulator_if
// Description : Upstream product capture, clear and result handshake bundle
//               shared by the product accumulator and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_product_accumulator_if #(
    parameter int LEN   = 32,
    parameter int TERMS = 4,
    parameter int GUARD = 4
);
    localparam int c_ACC_W = 2*LEN + GUARD;
    localparam int c_CNT_W = $clog2(TERMS + 1);

    logic                 clear;
    logic [2*LEN-1:0]     mul_product;
    logic                 mul_finish;
    logic [c_ACC_W-1:0]   acc_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [c_CNT_W-1:0]   term_cnt;
    logic                 overflow;
    logic                 lost;

    modport master (
        output clear, mul_product, mul_finish, out_ready,
        input  acc_out, out_valid, term_cnt, overflow, lost
    );

    modport slave (
        input  clear, mul_product, mul_finish, out_ready,
        output acc_out, out_valid, term_cnt, overflow, lost
    );
endinterface
`default_nettype wire

// File: rtl/mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mul_product_accumulator
// Description : Captures each new multiplier product once and sums TERMS of
//               them into a wide result offered on a valid/ready port.
//               Optional macro ACC_SATURATE_EN: clamp working sum on carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_product_accumulator #(
    parameter int LEN   = 32,
    parameter int TERMS = 4,
    parameter int GUARD = 4
) (
    input  wire  clk,
    input  wire  rst,
    mul_product_accumulator_if.slave bus
);
    localparam int c_PRD_W = 2*LEN;
    localparam int c_ACC_W = 2*LEN + GUARD;
    localparam int c_CNT_W = $clog2(TERMS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TERMS - 1);

    logic                 finish_q, finish_d;
    logic [c_ACC_W-1:0]   sum_q,    sum_d;
    logic [c_CNT_W-1:0]   cnt_q,    cnt_d;
    logic [c_ACC_W-1:0]   acc_q,    acc_d;
    logic                 valid_q,  valid_d;
    logic                 ovf_q,    ovf_d;
    logic                 lost_q,   lost_d;

    logic                 w_capture;
    logic                 w_xfer;
    logic [c_ACC_W:0]     w_add;
    logic                 w_carry;
    logic [c_ACC_W-1:0]   w_sum_next;

    // Rising edge of the level-style finish; finish_q resets high so a
    // finish already asserted out of reset is ignored.
    assign w_capture = bus.mul_finish & ~finish_q;
    assign w_xfer    = valid_q & bus.out_ready;

    assign w_add   = {1'b0, sum_q} + {{(c_ACC_W + 1 - c_PRD_W){1'b0}}, bus.mul_product};
    assign w_carry = w_add[c_ACC_W];

`ifdef ACC_SATURATE_EN
    assign w_sum_next = w_carry ? {c_ACC_W{1'b1}} : w_add[c_ACC_W-1:0];
`else
    assign w_sum_next = w_add[c_ACC_W-1:0];
`endif

    always_comb begin
        finish_d = bus.mul_finish;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        lost_d   = lost_q;

        if (w_xfer) begin
            valid_d = 1'b0;
        end

        if (bus.clear) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (w_capture) begin
            ovf_d = ovf_q | w_carry;
            if (cnt_q == c_LAST) begin
                sum_d = '0;
                cnt_d = '0;
                // A completing batch may overwrite the output only when it is
                // empty or being drained this very cycle.
                if (!valid_q || bus.out_ready) begin
                    acc_d   = w_sum_next;
                    valid_d = 1'b1;
                end else begin
                    lost_d = 1'b1;
                end
            end else begin
                sum_d = w_sum_next;
                cnt_d = cnt_q + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            finish_q <= 1'b1;
            sum_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            finish_q <= finish_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            lost_q   <= lost_d;
        end
    end

    assign bus.acc_out   = acc_q;
    assign bus.out_valid = valid_q;
    assign bus.term_cnt  = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.lost      = lost_q;
endmodule
`default_nettype wire

// File: tb/tb_mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_product_accumulator
// Description : Directed self-checking bench for mul_product_accumulator
//               (TERMS=4/GUARD=2 instance plus a TERMS=3/GUARD=1 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_product_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_product_accumulator_if #(.LEN(8), .TERMS(4), .GUARD(2)) a_if ();
    mul_product_accumulator_if #(.LEN(8), .TERMS(3), .GUARD(1)) b_if ();

    mul_product_accumulator #(.LEN(8), .TERMS(4), .GUARD(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    mul_product_accumulator #(.LEN(8), .TERMS(3), .GUARD(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise finish for one capture edge; returns with finish low again.
    task automatic pulse_hi_a(input logic [15:0] p);
        a_if.mul_product = p;
        a_if.mul_finish  = 1'b1;
        step();
        a_if.mul_finish  = 1'b0;
    endtask

    task automatic pulse_a(input logic [15:0] p);
        pulse_hi_a(p);
        step();
    endtask

    task automatic pulse_hi_b(input logic [15:0] p);
        b_if.mul_product = p;
        b_if.mul_finish  = 1'b1;
        step();
        b_if.mul_finish  = 1'b0;
    endtask

    task automatic pulse_b(input logic [15:0] p);
        pulse_hi_b(p);
        step();
    endtask

    logic [31:0] exp_sat;

    initial begin
        a_if.clear = 1'b0; a_if.mul_product = '0; a_if.mul_finish = 1'b0; a_if.out_ready = 1'b1;
        b_if.clear = 1'b0; b_if.mul_product = '0; b_if.mul_finish = 1'b0; b_if.out_ready = 1'b1;

        step(); step();
        check("rst_acc",   a_if.acc_out,   0);
        check("rst_valid", a_if.out_valid, 0);
        check("rst_cnt",   a_if.term_cnt,  0);
        check("rst_ovf",   a_if.overflow,  0);
        check("rst_lost",  a_if.lost,      0);
        rst = 1'b0;
        step();

        // Basic batch 3+5+7+9
        pulse_a(3); pulse_a(5); pulse_a(7);
        check("b1_cnt3", a_if.term_cnt, 3);
        check("b1_valid_pre", a_if.out_valid, 0);
        pulse_hi_a(9);
        check("b1_acc",   a_if.acc_out,   24);
        check("b1_valid", a_if.out_valid, 1);
        check("b1_cnt0",  a_if.term_cnt,  0);
        step();
        check("b1_drain", a_if.out_valid, 0);

        // Held-high finish counts once
        a_if.mul_product = 100;
        a_if.mul_finish  = 1'b1;
        for (int i = 0; i < 10; i++) step();
        a_if.mul_finish  = 1'b0;
        step();
        check("hold_cnt1", a_if.term_cnt, 1);
        pulse_a(1); pulse_a(1);
        check("hold_cnt3",  a_if.term_cnt,  3);
        check("hold_novld", a_if.out_valid, 0);
        pulse_hi_a(0);
        check("hold_acc",   a_if.acc_out,   102);
        check("hold_valid", a_if.out_valid, 1);
        step();

        // Back-pressure: second batch is dropped
        a_if.out_ready = 1'b0;
        pulse_a(1); pulse_a(1); pulse_a(1); pulse_hi_a(1);
        check("bp_acc1",   a_if.acc_out,   4);
        check("bp_valid1", a_if.out_valid, 1);
        step();
        pulse_a(2); pulse_a(2); pulse_a(2); pulse_hi_a(2);
        check("bp_acc_held", a_if.acc_out,   4);
        check("bp_lost",     a_if.lost,      1);
        check("bp_valid2",   a_if.out_valid, 1);
        check("bp_cnt0",     a_if.term_cnt,  0);
        a_if.out_ready = 1'b1;
        step();
        check("bp_xfer",      a_if.out_valid, 0);
        check("bp_lost_stky", a_if.lost,      1);

        // Clear with coincident capture
        pulse_a(10); pulse_a(20);
        check("clr_cnt2", a_if.term_cnt, 2);
        a_if.mul_product = 30;
        a_if.mul_finish  = 1'b1;
        a_if.clear       = 1'b1;
        step();
        a_if.clear      = 1'b0;
        a_if.mul_finish = 1'b0;
        check("clr_cnt0", a_if.term_cnt, 0);
        step();
        pulse_a(1); pulse_a(2); pulse_a(3); pulse_hi_a(4);
        check("clr_acc",   a_if.acc_out,   10);
        check("clr_valid", a_if.out_valid, 1);
        check("a_no_ovf",  a_if.overflow,  0);
        step();
        check("clr_drain", a_if.out_valid, 0);

        // Overflow instance: 3 x 65025 into 17 bits
        pulse_b(65025); pulse_b(65025);
        check("ov_cnt2",  b_if.term_cnt, 2);
        check("ov_ovf0",  b_if.overflow, 0);
        pulse_hi_b(65025);
`ifdef ACC_SATURATE_EN
        exp_sat = 131071;
`else
        exp_sat = 64003;
`endif
        check("ov_acc",   b_if.acc_out,   exp_sat);
        check("ov_ovf1",  b_if.overflow,  1);
        check("ov_valid", b_if.out_valid, 1);
        step();

        // Reset mid-batch with pending output and finish held high
        a_if.out_ready = 1'b0;
        pulse_a(1); pulse_a(1); pulse_a(1); pulse_hi_a(1);
        step();
        pulse_a(5); pulse_a(5);
        check("mr_cnt2",  a_if.term_cnt,  2);
        check("mr_valid", a_if.out_valid, 1);
        a_if.mul_product = 7;
        a_if.mul_finish  = 1'b1;
        rst = 1'b1;
        step();
        check("mr_acc",   a_if.acc_out,   0);
        check("mr_vld0",  a_if.out_valid, 0);
        check("mr_cnt0",  a_if.term_cnt,  0);
        check("mr_lost0", a_if.lost,      0);
        check("mr_ovf0",  b_if.overflow,  0);
        rst = 1'b0;
        step(); step(); step();
        check("mr_held_nocount", a_if.term_cnt, 0);
        a_if.mul_finish = 1'b0;
        step();
        pulse_a(8);
        check("mr_recount", a_if.term_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mul_product_accumulator.md
Name: mul_product_accumulator

Overview:
- Downstream consumer of the sequential shift-add multiplier.
- Watches the multiplier's level-style `finish`/`product` outputs and captures each new product once.
- Sums TERMS consecutive products into a wide accumulator; presents each completed sum on a valid/ready output port.
- Forms the accumulate half of a dot-product/MAC path built around the multiplier.

Parameters:
- LEN, 32, operand width of upstream multiplier; product is 2*LEN bits.
- TERMS, 4, products summed per result (>=1).
- GUARD, 4, extra accumulator MSBs; ACC_W = 2*LEN+GUARD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  sync flush of working sum and term count.
- mul_product  in  2*LEN  upstream product, valid while mul_finish high.
- mul_finish  in  1  upstream done, level (stays high until next job).
- acc_out  out  ACC_W  completed sum.
- out_valid  out  1  acc_out valid.
- out_ready  in  1  consumer accepts acc_out.
- term_cnt  out  $clog2(TERMS+1)  products in current working sum.
- overflow  out  1  sticky; working-sum carry-out occurred.
- lost  out  1  sticky; completed sum dropped because output was still held.

Behaviour:
- Reset (rst=1 at clk edge): acc_out=0, out_valid=0, term_cnt=0, working sum=0, overflow=0, lost=0, finish_d=1.
  - Because finish_d resets to 1, a finish already high out of reset is not counted.
- Capture event: mul_finish=1 and finish_d=0 (rising edge). finish_d <= mul_finish every cycle.
  - A held-high finish counts exactly once.
- On capture with term_cnt < TERMS-1: sum <= sum + zero-extended mul_product; term_cnt++.
  - Updated values visible the next cycle (1-cycle latency).
- On capture with term_cnt == TERMS-1 (batch complete):
  - If out_valid=0, or out_ready=1 this cycle: acc_out <= sum + mul_product, out_valid <= 1.
  - Otherwise: lost <= 1 and acc_out is unchanged.
  - In both cases sum <= 0 and term_cnt <= 0.
- Output handshake: transfer when out_valid && out_ready. acc_out is stable while out_valid=1 and out_ready=0.
  - Transfer with no batch completing that cycle: out_valid <= 0.
  - Transfer and batch completing in the same cycle: out_valid stays 1 and acc_out takes the new sum (back-to-back).
- Working sum and output register are independent. Accumulation of the next batch continues while a result is pending.
- clear=1: sum <= 0, term_cnt <= 0, and a coincident capture is discarded.
  - out_valid, acc_out, overflow and lost are unaffected.
  - finish_d still updates.
- Arithmetic: unsigned, modulo 2^ACC_W.
  - Carry-out of any add sets overflow (sticky until rst).
- rst has priority over clear, which has priority over capture.
- TERMS=1: every capture produces a result directly.

Optional Feature:
- Macro ACC_SATURATE_EN.
  - Defined: on carry-out the working sum clamps to 2^ACC_W-1 and stays there for the rest of the batch. overflow is still set.
  - Undefined: wrap modulo 2^ACC_W. overflow is set.

Test Plan (LEN=8, TERMS=4, GUARD=2 unless stated):
- Products 3,5,7,9, each a separate finish low->high pulse, out_ready=1 -> out_valid rises the cycle after the 4th capture, acc_out=24, term_cnt returns to 0.
- mul_finish held high 10 cycles with product 100, then two more pulses of 1 and 1 -> only one capture of 100; after the 4th term acc_out=102 only if a 4th pulse of 0 follows, otherwise term_cnt=3 and out_valid stays 0.
- out_ready=0; batch 1,1,1,1 then batch 2,2,2,2 -> acc_out stays 4, lost=1; then out_ready=1 -> one transfer, out_valid=0.
- GUARD=1 (ACC_W=17), TERMS=3, products 65025 x3:
  - Without ACC_SATURATE_EN: acc_out=64003, overflow=1.
  - With ACC_SATURATE_EN: acc_out=131071, overflow=1.
- After 2 terms (10,20), assert clear with a coincident capture -> term_cnt=0; next 1,2,3,4 -> acc_out=10.
- rst asserted while out_valid=1 and term_cnt=2 -> next cycle all outputs 0; a finish that stays high after reset is not counted.
